mult_div_issue_queue: RTL and testbench

In-order reservation queue for the multiply/divide path, directly downstream of the dispatch packager. It accepts `queue_data` packets qualified by `en_mult_dispatch` / `en_div_dispatch`, holds up to `DEPTH` entries, and snoops the CDB to wake up pending operands. The head entry issues to the multiplier or divider through a valid/ready handshake once both operands are valid.

---
 rtl/mult_div_issue_queue.sv | 145 ++++++++++++++
 tb/tb_mult_div_issue_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_issue_queue.sv
// In-order mult/div reservation queue with CDB operand wakeup and valid/ready issue.
// Optional MDQ_DISPATCH_CDB_BYPASS_EN: capture a CDB broadcast that coincides with the push.
package mult_div_issue_queue_pkg;
  typedef struct packed {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [5:0]  rs1_tag;
    logic [5:0]  rs2_tag;
    logic [5:0]  rd_tag;
    logic        rs1_data_valid;
    logic        rs2_data_valid;
  } queue_data;
endpackage

module mult_div_issue_queue
  import mult_div_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  queue_data   dispatch_data,
  input  logic        en_mult_dispatch,
  input  logic        en_div_dispatch,
  output logic        queue_full,
  output logic        queue_empty,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        flush,
  output logic        issue_valid,
  output logic        issue_is_div,
  output logic [31:0] issue_rs1_data,
  output logic [31:0] issue_rs2_data,
  output logic [5:0]  issue_rd_tag,
  input  logic        mult_ready,
  input  logic        div_ready
);

  queue_data        ent_q [DEPTH];
  queue_data        ent_d [DEPTH];
  logic [DEPTH-1:0] is_div_q, is_div_d;
  logic [DEPTH-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  queue_data head;
  queue_data push_pkt;
  logic      push, pop;

  assign queue_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign queue_empty = (count_q == '0);
  assign head        = ent_q[rd_ptr_q];

  // Issue side sees only registered head state; ready feeds pop, never issue_valid.
  always_comb begin
    issue_valid    = !queue_empty && head.rs1_data_valid && head.rs2_data_valid;
    issue_is_div   = 1'b0;
    issue_rs1_data = '0;
    issue_rs2_data = '0;
    issue_rd_tag   = '0;
    if (issue_valid) begin
      issue_is_div   = is_div_q[rd_ptr_q];
      issue_rs1_data = head.rs1_data;
      issue_rs2_data = head.rs2_data;
      issue_rd_tag   = head.rd_tag;
    end
  end

  assign push = (en_mult_dispatch ^ en_div_dispatch) && !queue_full;
  assign pop  = issue_valid && (is_div_q[rd_ptr_q] ? div_ready : mult_ready);

  always_comb begin
    push_pkt = dispatch_data;
`ifdef MDQ_DISPATCH_CDB_BYPASS_EN
    if (cdb_valid && !dispatch_data.rs1_data_valid && dispatch_data.rs1_tag == cdb_tag) begin
      push_pkt.rs1_data       = cdb_data;
      push_pkt.rs1_data_valid = 1'b1;
    end
    if (cdb_valid && !dispatch_data.rs2_data_valid && dispatch_data.rs2_tag == cdb_tag) begin
      push_pkt.rs2_data       = cdb_data;
      push_pkt.rs2_data_valid = 1'b1;
    end
`endif
  end

  always_comb begin
    ent_d    = ent_q;
    is_div_d = is_div_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ_q[i] && cdb_valid && !ent_q[i].rs1_data_valid && ent_q[i].rs1_tag == cdb_tag) begin
          ent_d[i].rs1_data       = cdb_data;
          ent_d[i].rs1_data_valid = 1'b1;
        end
        if (occ_q[i] && cdb_valid && !ent_q[i].rs2_data_valid && ent_q[i].rs2_tag == cdb_tag) begin
          ent_d[i].rs2_data       = cdb_data;
          ent_d[i].rs2_data_valid = 1'b1;
        end
      end
      if (pop) begin
        occ_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      // Push is gated by the registered full flag, so it never lands on the slot being popped.
      if (push) begin
        ent_d[wr_ptr_q]    = push_pkt;
        is_div_d[wr_ptr_q] = en_div_dispatch;
        occ_d[wr_ptr_q]    = 1'b1;
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      is_div_q <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_q    <= ent_d;
      is_div_q <= is_div_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_mult_div_issue_queue.sv
// Bench for mult_div_issue_queue: directed scenarios plus random traffic against a queue-based model.
module tb_mult_div_issue_queue;
  import mult_div_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  queue_data   dispatch_data;
  logic        en_mult_dispatch, en_div_dispatch;
  logic        queue_full, queue_empty;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        issue_valid, issue_is_div;
  logic [31:0] issue_rs1_data, issue_rs2_data;
  logic [5:0]  issue_rd_tag;
  logic        mult_ready, div_ready;

  int checks = 0;
  int failures = 0;

  queue_data mq[$];
  bit        mdiv[$];

  mult_div_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .dispatch_data(dispatch_data),
    .en_mult_dispatch(en_mult_dispatch), .en_div_dispatch(en_div_dispatch),
    .queue_full(queue_full), .queue_empty(queue_empty),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .flush(flush),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_tag(issue_rd_tag), .mult_ready(mult_ready), .div_ready(div_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    dispatch_data    = '0;
    en_mult_dispatch = 0;
    en_div_dispatch  = 0;
    cdb_valid        = 0;
    cdb_tag          = '0;
    cdb_data         = '0;
    flush            = 0;
  endtask

  function automatic queue_data pkt(input logic [31:0] a, input logic [31:0] b,
                                    input logic va, input logic vb,
                                    input logic [5:0] ta, input logic [5:0] tb, input logic [5:0] rd);
    queue_data p;
    p.rs1_data = a; p.rs2_data = b; p.rs1_data_valid = va; p.rs2_data_valid = vb;
    p.rs1_tag = ta; p.rs2_tag = tb; p.rd_tag = rd;
    return p;
  endfunction

  // Model step: squash, or retire head, wake operands, append the new packet.
  task automatic model_update();
    int        n;
    bit        hv, do_pop, do_push;
    queue_data p;
    if (flush) begin
      mq.delete(); mdiv.delete();
      return;
    end
    n       = mq.size();
    do_push = (en_mult_dispatch != en_div_dispatch) && (n < DEPTH);
    hv      = (n > 0) && mq[0].rs1_data_valid && mq[0].rs2_data_valid;
    do_pop  = hv && (mdiv[0] ? div_ready : mult_ready);
    if (cdb_valid)
      foreach (mq[i]) begin
        if (!mq[i].rs1_data_valid && mq[i].rs1_tag == cdb_tag) begin
          mq[i].rs1_data = cdb_data; mq[i].rs1_data_valid = 1;
        end
        if (!mq[i].rs2_data_valid && mq[i].rs2_tag == cdb_tag) begin
          mq[i].rs2_data = cdb_data; mq[i].rs2_data_valid = 1;
        end
      end
    if (do_pop) begin
      void'(mq.pop_front()); void'(mdiv.pop_front());
    end
    if (do_push) begin
      p = dispatch_data;
`ifdef MDQ_DISPATCH_CDB_BYPASS_EN
      if (cdb_valid && !p.rs1_data_valid && p.rs1_tag == cdb_tag) begin
        p.rs1_data = cdb_data; p.rs1_data_valid = 1;
      end
      if (cdb_valid && !p.rs2_data_valid && p.rs2_tag == cdb_tag) begin
        p.rs2_data = cdb_data; p.rs2_data_valid = 1;
      end
`endif
      mq.push_back(p); mdiv.push_back(en_div_dispatch);
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = (mq.size() > 0) && mq[0].rs1_data_valid && mq[0].rs2_data_valid;
    chk("issue_valid", issue_valid, ev);
    chk("issue_is_div", issue_is_div, ev ? mdiv[0] : 1'b0);
    chk("issue_rs1", issue_rs1_data, ev ? mq[0].rs1_data : 32'd0);
    chk("issue_rs2", issue_rs2_data, ev ? mq[0].rs2_data : 32'd0);
    chk("issue_rd", issue_rd_tag, ev ? mq[0].rd_tag : 6'd0);
    chk("queue_full", queue_full, mq.size() == DEPTH);
    chk("queue_empty", queue_empty, mq.size() == 0);
  endtask

  // Inputs already set; clock them in, advance the model, check at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic push(input bit is_div, input queue_data p);
    idle();
    dispatch_data    = p;
    en_div_dispatch  = is_div;
    en_mult_dispatch = !is_div;
    cycle();
  endtask

  initial begin
    idle();
    mult_ready = 0; div_ready = 0;
    rst_n = 0;
    #12;
    check_all();
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_empty", queue_empty, 1);
    @(negedge clk) rst_n = 1;

    // Ready mult issues the cycle after push and retires on the next edge.
    mult_ready = 1;
    push(0, pkt(7, 6, 1, 1, 0, 0, 5));
    chk("t1_valid", issue_valid, 1);
    chk("t1_rs1", issue_rs1_data, 7);
    chk("t1_rs2", issue_rs2_data, 6);
    chk("t1_rd", issue_rd_tag, 5);
    idle(); cycle();
    chk("t1_empty", queue_empty, 1);

    // Divide waits on CDB wakeup of rs2.
    div_ready = 1;
    push(1, pkt(20, 0, 1, 0, 0, 6'h12, 9));
    idle();
    repeat (3) begin cycle(); chk("t2_wait", issue_valid, 0); end
    cdb_valid = 1; cdb_tag = 6'h12; cdb_data = 3;
    cycle();
    chk("t2_valid", issue_valid, 1);
    chk("t2_rs2", issue_rs2_data, 3);
    idle(); cycle();

    // Fill, drop 5th push, then drain in order with concurrent pushes.
    mult_ready = 0;
    for (int i = 0; i < 5; i++) push(0, pkt(100 + i, i, 1, 1, 0, 0, 6'(i + 1)));
    chk("t3_full", queue_full, 1);
    mult_ready = 1;
    for (int i = 0; i < 6; i++) begin
      push(0, pkt(200 + i, i, 1, 1, 0, 0, 6'(i + 10)));
      idle();
    end
    repeat (5) cycle();
    chk("t3_drained", queue_empty, 1);

    // Blocked divide head holds back a ready mult.
    div_ready = 0; mult_ready = 1;
    push(1, pkt(1, 2, 1, 1, 0, 0, 20));
    push(0, pkt(3, 4, 1, 1, 0, 0, 21));
    idle();
    repeat (3) begin cycle(); chk("t4_head_div", issue_is_div, 1); end
    div_ready = 1; cycle();
    chk("t4_mult_next", issue_rd_tag, 21);
    cycle();

    // Flush wins over a same-cycle push.
    mult_ready = 0;
    for (int i = 0; i < 3; i++) push(0, pkt(i, i, 1, 1, 0, 0, 6'(30 + i)));
    dispatch_data = pkt(9, 9, 1, 1, 0, 0, 40); en_mult_dispatch = 1; flush = 1;
    cycle();
    chk("t5_flush_empty", queue_empty, 1);
    idle(); mult_ready = 1;
    repeat (2) begin cycle(); chk("t5_no_issue", issue_valid, 0); end

    // Async reset mid-drain.
    mult_ready = 0;
    for (int i = 0; i < 3; i++) push(0, pkt(i, i, 1, 1, 0, 0, 6'(50 + i)));
    idle(); mult_ready = 1; cycle();
    #2 rst_n = 0;
    #1;
    chk("t5_rst_valid", issue_valid, 0);
    chk("t5_rst_empty", queue_empty, 1);
    mq.delete(); mdiv.delete();
    @(negedge clk) rst_n = 1;

    // Push coinciding with a matching broadcast.
    mult_ready = 1;
    idle();
    dispatch_data = pkt(0, 5, 0, 1, 6'd9, 0, 60); en_mult_dispatch = 1;
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'hABCD;
    cycle();
`ifdef MDQ_DISPATCH_CDB_BYPASS_EN
    chk("t6_bypass_valid", issue_valid, 1);
    chk("t6_bypass_rs1", issue_rs1_data, 32'hABCD);
`else
    chk("t6_pending", issue_valid, 0);
`endif
    idle();
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h1234;
    cycle();
    idle(); cycle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      idle();
      r = $urandom_range(0, 9);
      if (r < 3) en_mult_dispatch = 1;
      else if (r < 6) en_div_dispatch = 1;
      else if (r == 6) begin en_mult_dispatch = 1; en_div_dispatch = 1; end
      dispatch_data = pkt($urandom, $urandom, 1'($urandom), 1'($urandom),
                          6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom));
      cdb_valid  = ($urandom_range(0, 2) == 0);
      cdb_tag    = 6'($urandom_range(0, 7));
      cdb_data   = $urandom;
      flush      = ($urandom_range(0, 63) == 0);
      mult_ready = ($urandom_range(0, 2) != 0);
      div_ready  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
